// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Read-side sequencer for a 1W/1R SRAM whose read port has 1-cycle latency
//   and an active-low enable. A start pulse launches a job that reads len
//   consecutive words from base. The words are presented as a valid/ready
//   stream through a 2-entry skid FIFO, which absorbs the read latency under
//   backpressure.
//
// Build option
//   SRAM_RD_WRAP_EN : when defined, the read address wraps at DEPTH
//                     (DEPTH-1 -> 0). When undefined, the address wraps
//                     naturally modulo 2^WADDR.
//
// Ports
//   clk       in   single clock (block and SRAM read port)
//   rstn      in   asynchronous active-low reset
//   start     in   job request pulse, accepted only while idle
//   base      in   first word address, latched on accepted start
//   len       in   word count, latched on accepted start (0 = empty job)
//   busy      out  job in progress
//   done      out  1-cycle pulse after the last word is accepted
//   sram_cen  out  SRAM read enable, active-low
//   sram_a    out  SRAM read address
//   sram_q    in   SRAM read data, valid 1 cycle after sram_cen==0
//   m_valid   out  stream data valid
//   m_data    out  stream data (FIFO head)
//   m_ready   in   downstream accept
module sram_stream_reader #(
  parameter int WWORD = 32,
  parameter int WADDR = 5,
  parameter int DEPTH = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WADDR-1:0] base,
  input  logic [WADDR:0]   len,
  output logic             busy,
  output logic             done,
  output logic             sram_cen,
  output logic [WADDR-1:0] sram_a,
  input  logic [WWORD-1:0] sram_q,
  output logic             m_valid,
  output logic [WWORD-1:0] m_data,
  input  logic             m_ready
);

  // The address ring can never be larger than the address space.
  if (DEPTH < 1 || DEPTH > (1 << WADDR)) begin : g_bad_depth
    $error("sram_stream_reader: DEPTH must be in 1..2^WADDR");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WADDR-1:0] addr_q;
  logic [WADDR-1:0] addr_d;
  logic [WADDR:0]   rem_issue_q;
  logic [WADDR:0]   rem_pop_q;
  logic             inflight_q;
  logic [WWORD-1:0] fifo_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       fifo_cnt_q;

  logic             accept_s;
  logic             pop_s;
  logic             last_pop_s;
  logic             issue_s;
  logic [2:0]       occ_s;

  assign accept_s   = (state_q == S_IDLE) && start;
  assign pop_s      = (fifo_cnt_q != 2'd0) && m_ready;
  assign last_pop_s = pop_s && (rem_pop_q == (WADDR+1)'(1));

  // Words already committed (buffered or in flight). A read may only be
  // issued if it still fits once this cycle's pop is accounted for, which
  // keeps the FIFO from overflowing without stalling a full-rate stream.
  assign occ_s   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign issue_s = (state_q == S_RUN) && (rem_issue_q != (WADDR+1)'(0)) &&
                   (occ_s < (3'd2 + {2'b00, pop_s}));

  assign busy     = busy_q;
  assign done     = done_q;
  assign sram_cen = ~issue_s;
  assign sram_a   = addr_q;
  assign m_valid  = (fifo_cnt_q != 2'd0);
  assign m_data   = fifo_q[rd_ptr_q];

  // Next read address after an issue.
  always_comb begin
`ifdef SRAM_RD_WRAP_EN
    if (addr_q == WADDR'(DEPTH - 1)) begin
      addr_d = '0;
    end else begin
      addr_d = addr_q + WADDR'(1);
    end
`else
    addr_d = addr_q + WADDR'(1);
`endif
  end

  // Job-control FSM with registered busy/done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != (WADDR+1)'(0)) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last_pop_s) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address and remaining-word counters; loaded only when a job is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_pop_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue_s;
      if (accept_s) begin
        addr_q      <= base;
        rem_issue_q <= len;
        rem_pop_q   <= len;
      end else begin
        if (issue_s) begin
          addr_q      <= addr_d;
          rem_issue_q <= rem_issue_q - (WADDR+1)'(1);
        end
        if (pop_s && (rem_pop_q != (WADDR+1)'(0))) begin
          rem_pop_q <= rem_pop_q - (WADDR+1)'(1);
        end
      end
    end
  end

  // Two-entry skid FIFO: push returning read data, pop on handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= sram_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Testbench for sram_stream_reader: directed jobs plus randomized ones,
// checked against a queue-based model of the address/data sequence.
module tb_sram_stream_reader;
  localparam int WWORD = 32;
  localparam int WADDR = 5;
  localparam int DEPTH = 24;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [WADDR-1:0] base;
  logic [WADDR:0]   len;
  logic             busy;
  logic             done;
  logic             sram_cen;
  logic [WADDR-1:0] sram_a;
  logic [WWORD-1:0] sram_q;
  logic             m_valid;
  logic [WWORD-1:0] m_data;
  logic             m_ready;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [WWORD-1:0] mem [32];

  sram_stream_reader #(.WWORD(WWORD), .WADDR(WADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .sram_cen(sram_cen), .sram_a(sram_a),
    .sram_q(sram_q), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // SRAM read port model: 1-cycle latency, active-low enable.
  always @(posedge clk) begin
    if (sram_cen === 1'b0) sram_q <= mem[sram_a];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word i of a job starting at b lives at this address.
  function automatic logic [WADDR-1:0] model_addr(input int b, input int i);
`ifdef SRAM_RD_WRAP_EN
    return WADDR'((b + i) % DEPTH);
`else
    return WADDR'((b + i) % 32);
`endif
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},     64'(busy),     64'(0));
    check({pfx, "_done"},     64'(done),     64'(0));
    check({pfx, "_sram_cen"}, 64'(sram_cen), 64'(1));
    check({pfx, "_sram_a"},   64'(sram_a),   64'(0));
    check({pfx, "_m_valid"},  64'(m_valid),  64'(0));
    check({pfx, "_m_data"},   64'(m_data),   64'(0));
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0,..., 2 random ready.
  // restart: pulse a different start mid-job. abort_after>=0: reset after that many pops.
  task automatic run_job(input int b, input int l, input int mode, input bit restart,
                         input int abort_after);
    logic [WADDR-1:0] exp_addr [$];
    logic [WWORD-1:0] exp_data [$];
    int               issued   = 0;
    int               popped   = 0;
    int               last_pop = 0;
    bit               finished = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WWORD-1:0] prev_data = '0;
    bit               pop;
    for (int i = 0; i < l; i++) begin
      exp_addr.push_back(model_addr(b, i));
      exp_data.push_back(mem[model_addr(b, i)]);
    end
    @(posedge clk); #1;
    start   = 1'b1;
    base    = WADDR'(b);
    len     = (WADDR+1)'(l);
    m_ready = ready_for(mode, 0);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      pop = m_valid && m_ready;
      check("busy", 64'(busy), 64'(l != 0 && cyc >= 1 && popped < l));
      check("done", 64'(done), 64'(popped == l && cyc == last_pop + 1));
      if (mode == 0 && cyc <= l + 3) begin
        check("m_valid_seq", 64'(m_valid), 64'(cyc >= 3 && cyc <= l + 2));
        check("cen_seq", 64'(sram_cen), 64'(!(cyc >= 1 && cyc <= l)));
      end
      if (sram_cen === 1'b0) begin
        if (exp_addr.size() == 0) begin
          check("extra_read", 64'(sram_cen), 64'(1));
        end else begin
          check("sram_a", 64'(sram_a), 64'(exp_addr.pop_front()));
          check("issue_rule", 64'((issued - popped - int'(pop)) < 2), 64'(1));
        end
        issued++;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'(1));
        check("stall_data", 64'(m_data), 64'(prev_data));
      end
      if (pop) begin
        if (exp_data.size() == 0) check("extra_word", 64'(m_valid), 64'(0));
        else check("m_data", 64'(m_data), 64'(exp_data.pop_front()));
        popped++;
        last_pop = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (abort_after >= 0 && popped == abort_after) begin
        rstn  = 1'b0;
        start = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        return;
      end
      if (popped >= l && cyc >= last_pop + 2) begin
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        start = restart && (cyc + 1 == 3);
        if (start) begin
          base = WADDR'($urandom_range(0, DEPTH - 1));
          len  = (WADDR+1)'($urandom_range(1, 20));
        end
        m_ready = ready_for(mode, cyc + 1);
      end
    end
    if (!finished) check("timeout_popped", 64'(popped), 64'(l));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    sram_q  = '0;
    rstn    = 1'b0;
    start   = 1'b0;
    base    = '0;
    len     = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rstn = 1'b1;

    run_job(3, 4, 0, 1'b0, -1);    // basic full-rate job
    run_job(0, 8, 1, 1'b0, -1);    // backpressure pattern 1,0,0
    run_job(5, 0, 0, 1'b0, -1);    // empty job
    run_job(22, 4, 0, 1'b0, -1);   // address wrap
    run_job(10, 6, 2, 1'b1, -1);   // start while busy is ignored
    run_job(0, 6, 0, 1'b0, 2);     // reset after 2 pops
    run_job(0, 2, 0, 1'b0, -1);    // clean job after abort
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)), 2, 1'b0, -1);
    end
    run_job(1, 30, 0, 1'b0, -1);   // long job, exercises wrap and sustained rate

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
